// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and the single-port data memory.
// Loads own the memory port and forward from buffered stores; stores drain in FIFO order when the port is free.
module store_buffer #(
    parameter int SIZE       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            st_valid,
    input  logic [SIZE-1:0] st_addr,
    input  logic [SIZE-1:0] st_data,
    output logic            st_ready,
    input  logic            ld_valid,
    input  logic [SIZE-1:0] ld_addr,
    output logic [SIZE-1:0] ld_data,
    output logic            ld_hit,
    output logic            ld_stall,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_a,
    output logic [SIZE-1:0] mem_wd,
    input  logic [SIZE-1:0] mem_rd,
    output logic            sb_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_FORCE = 2'd3
    } arb_e;

    arb_e            arb;
    logic [SIZE-1:0] addr_q [DEPTH];
    logic [SIZE-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            enq, pop, fwd_hit;
    logic [SIZE-1:0] fwd_data;

    // Store handshake: a store transfers on a cycle where st_valid && st_ready;
    // st_ready comes from registered count only, so a full buffer never accepts even while draining.
    always_comb begin
        arb = ARB_IDLE;
        if (count_q != '0 && starve_q == SW'(STARVE_MAX)) begin
            arb = ARB_FORCE;
        end else if (ld_valid) begin
            arb = ARB_LOAD;
        end else if (count_q != '0) begin
            arb = ARB_DRAIN;
        end
    end

    always_comb begin
        st_ready = (count_q < CW'(DEPTH));
        sb_empty = (count_q == '0);
        enq      = st_valid && st_ready;
        pop      = (arb == ARB_FORCE) || (arb == ARB_DRAIN);
        // Gate the write during reset so pending stores are discarded rather than committed.
        mem_we   = pop && !RST;
        mem_a    = '0;
        mem_wd   = '0;
        ld_stall = 1'b0;
        case (arb)
            ARB_FORCE: begin
                mem_a    = addr_q[head_q];
                mem_wd   = data_q[head_q];
                ld_stall = ld_valid;
            end
            ARB_LOAD:  mem_a = ld_addr;
            ARB_DRAIN: begin
                mem_a  = addr_q[head_q];
                mem_wd = data_q[head_q];
            end
            default: ;
        endcase
    end

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && addr_q[idx] == ld_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
        ld_hit  = ld_valid && !ld_stall && fwd_hit;
        ld_data = fwd_hit ? fwd_data : mem_rd;
    end

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        starve_d = starve_q;
        if (pop || count_q == '0) begin
            starve_d = '0;
        end else if (arb == ARB_LOAD && starve_q < SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, checked against a queue-based model
// of pending stores, a starvation count and a reference copy of the 64-word data memory.
module tb_store_buffer;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        st_valid = 1'b0, ld_valid = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
    logic        st_ready, ld_hit, ld_stall, mem_we, sb_empty;
    logic [31:0] ld_data, mem_a, mem_wd, mem_rd;

    logic [31:0] dmem [64];
    logic        mem_init = 1'b1;

    logic [31:0] dmem_ref [64];
    logic [31:0] pend_addr_q [$];
    logic [31:0] pend_data_q [$];
    int          starve = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    store_buffer #(.SIZE(32), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .ld_stall(ld_stall), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .sb_empty(sb_empty)
    );

    always #5 CLK = ~CLK;

    assign mem_rd = dmem[mem_a[5:0]];
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h1000 + i;
        end else if (mem_we) begin
            dmem[mem_a[5:0]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la);
        int          sz;
        logic        frc, pop, found, acc;
        logic [31:0] fdata;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        @(negedge CLK);
        sz    = pend_addr_q.size();
        frc   = (sz > 0) && (starve == STARVE_MAX);
        pop   = frc || (!lv && sz > 0);
        acc   = sv && (sz < DEPTH);
        found = 1'b0;
        fdata = '0;
        for (int i = 0; i < sz; i++) begin
            if (pend_addr_q[i] == la) begin
                found = 1'b1;
                fdata = pend_data_q[i];
            end
        end
        check("st_ready", {31'd0, st_ready}, {31'd0, sz < DEPTH});
        check("sb_empty", {31'd0, sb_empty}, {31'd0, sz == 0});
        check("mem_we", {31'd0, mem_we}, {31'd0, pop});
        check("ld_stall", {31'd0, ld_stall}, {31'd0, lv && frc});
        check("ld_hit", {31'd0, ld_hit}, {31'd0, lv && !frc && found});
        if (pop) begin
            check("mem_a", mem_a, pend_addr_q[0]);
            check("mem_wd", mem_wd, pend_data_q[0]);
        end else if (lv) begin
            check("mem_a", mem_a, la);
            check("ld_data", ld_data, found ? fdata : dmem_ref[la[5:0]]);
        end else begin
            check("mem_a", mem_a, 32'd0);
            check("mem_wd", mem_wd, 32'd0);
        end
        @(posedge CLK);
        if (pop) begin
            dmem_ref[pend_addr_q[0][5:0]] = pend_data_q[0];
            void'(pend_addr_q.pop_front());
            void'(pend_data_q.pop_front());
        end
        if (acc) begin
            pend_addr_q.push_back(sa);
            pend_data_q.push_back(sd);
        end
        if (pop || sz == 0) starve = 0;
        else if (lv && starve < STARVE_MAX) starve++;
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        st_valid = 1'b0;
        ld_valid = 1'b0;
        @(negedge CLK);
        check("we_in_reset", {31'd0, mem_we}, 32'd0);
        @(posedge CLK);
        pend_addr_q.delete();
        pend_data_q.delete();
        starve = 0;
        #1;
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem_ref[i] = 32'h1000 + i;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        mem_init = 1'b0;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 1'b0, 0);

        // Single store drains on the next free cycle, then reads back from memory.
        step(1'b1, 32'd5, 32'hAA, 1'b0, 0);
        step(1'b0, 0, 0, 1'b0, 0);
        step(1'b0, 0, 0, 1'b1, 32'd5);

        // Continuous loads starve the buffer until a forced drain.
        for (int i = 1; i <= 4; i++) step(1'b1, i, 32'h11 * i, 1'b1, 32'd20);
        for (int i = 0; i < 14; i++) step(1'b1, 32'd30 + i, 32'h500 + i, 1'b1, 32'd21);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 0, 1'b0, 0);

        // Youngest match wins; a miss reads memory.
        step(1'b1, 32'd7, 32'h01, 1'b1, 32'd9);
        step(1'b1, 32'd7, 32'h02, 1'b1, 32'd9);
        step(1'b0, 0, 0, 1'b1, 32'd7);
        step(1'b0, 0, 0, 1'b1, 32'd8);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 0);

        // Fill, start draining, then reset: the undrained stores never land.
        for (int i = 0; i < 4; i++) step(1'b1, 32'd40 + i, 32'hBEEF0 + i, 1'b1, 32'd40);
        step(1'b0, 0, 0, 1'b0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 0);
        for (int i = 41; i < 44; i++) check("undrained", dmem[i], 32'h1000 + i);

        // Enqueue and drain together at count two; pointers wrap.
        step(1'b1, 32'd50, 32'hC0, 1'b1, 32'd0);
        step(1'b1, 32'd51, 32'hC1, 1'b1, 32'd0);
        for (int i = 2; i < 6; i++) step(1'b1, 32'd50 + i, 32'hC0 + i, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
                     1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 15)));
            end
        end
        for (int i = 0; i < 8; i++) step(1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 64; i++) check("dmem_final", dmem[i], dmem_ref[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
